// File: rtl/tx_core_pkg.sv
// Shared constants, source codes and FSM state type for the TX sample-path core.
// Source codes depend on the channel count, so they are provided as functions of it.
package tx_core_pkg;

  localparam int SEL_W = 5;
  localparam logic [15:0] GAIN_ONE = 16'h8000;
  localparam int ROUND_K = 1 << 14;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_MUTE = 1'b1
  } state_t;

  function automatic int sel_w();
    return SEL_W;
  endfunction

  function automatic logic [SEL_W-1:0] src_ramp(input int num_ch);
    return SEL_W'(num_ch);
  endfunction

  function automatic logic [SEL_W-1:0] src_zero(input int num_ch);
    return SEL_W'(num_ch + 1);
  endfunction

endpackage

// File: rtl/tx_core_mux_if.sv
// Sample-path bus between the capture fabric / control side and one TX core instance.
// master drives selection, gain and ADC samples; slave is the core producing DAC words.
interface tx_core_mux_if
  import tx_core_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SPC    = 8,
  parameter int SW     = 16
);

  logic [sel_w()-1:0]      output_select;
  logic [SW-1:0]           ramp_inc;
  logic [15:0]             gain;
  logic [NUM_CH*SPC*SW-1:0] adc_data;
  logic                    dbg_freeze;
  logic [SPC*SW-1:0]       dac_data;
  logic [SPC*SW-1:0]       dbg_output_data;
  logic                    sel_busy;

  modport master (
    output output_select, ramp_inc, gain, adc_data, dbg_freeze,
    input  dac_data, dbg_output_data, sel_busy
  );

  modport slave (
    input  output_select, ramp_inc, gain, adc_data, dbg_freeze,
    output dac_data, dbg_output_data, sel_busy
  );

endinterface

// File: rtl/tx_lane_gain_sat.sv
// One output lane: signed sample times unsigned Q1.15 gain, then round-half-up,
// shift back to sample scale and saturate. Two register stages.
module tx_lane_gain_sat
  import tx_core_pkg::*;
#(
  parameter int SW = 16
)(
  input  logic                 clock,
  input  logic                 reset,
  input  logic signed [SW-1:0] sample,
  input  logic [15:0]          gain,
  output logic signed [SW-1:0] result
);

  localparam int PW = SW + 17;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] g_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;
  logic signed [PW-1:0] sat_max;
  logic signed [PW-1:0] sat_min;
  logic signed [SW-1:0] sat;

  always_comb begin
    a_ext   = PW'(sample);
    g_ext   = PW'($signed({1'b0, gain}));
    rounded = prod + PW'(ROUND_K);
    shifted = rounded >>> 15;
    sat_max = PW'({1'b0, {(SW-1){1'b1}}});
    sat_min = ~sat_max;
    if (shifted > sat_max) begin
      sat = {1'b0, {(SW-1){1'b1}}};
    end else if (shifted < sat_min) begin
      sat = {1'b1, {(SW-1){1'b0}}};
    end else begin
      sat = shifted[SW-1:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod   <= '0;
      result <= '0;
    end else begin
      prod   <= a_ext * g_ext;
      result <= sat;
    end
  end

endmodule

// File: rtl/tx_core_mux.sv
// TX sample-path core: source select (ADC channel / ramp / zero) with a mute window on
// every source change, followed by a per-lane gain/round/saturate pipeline.
//
//   state   | meaning
//   ST_RUN  | active source flows into stage 1
//   ST_MUTE | stage 1 forced to zero while the new selection settles
module tx_core_mux
  import tx_core_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SPC         = 8,
  parameter int SW          = 16,
  parameter int MUTE_CYCLES = 16
)(
  input logic          clock,
  input logic          reset,
  tx_core_mux_if.slave bus
);

  localparam int LW    = SPC * SW;
  localparam int CNT_W = $clog2(MUTE_CYCLES + 1);
  localparam logic [SEL_W-1:0] SEL_RAMP = src_ramp(NUM_CH);
  localparam logic [SEL_W-1:0] SEL_ZERO = src_zero(NUM_CH);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] active_sel;
  logic [SEL_W-1:0] latched_sel;
  logic [SEL_W-1:0] dec_sel;
  logic             sel_busy;
  logic [SW-1:0]    ramp_acc;
  logic [LW-1:0]    ramp_word;
  logic [LW-1:0]    dec_word;
  logic [LW-1:0]    s1_d;
  logic [LW-1:0]    s1;
  logic [LW-1:0]    dbg_q;
  logic [LW-1:0]    dac_word;
  logic             stay_run;
  logic             exit_mute;

  always_comb begin
    ramp_word = '0;
    for (int k = 0; k < SPC; k++) begin
      ramp_word[k*SW +: SW] = ramp_acc + SW'(k) * bus.ramp_inc;
    end
  end

  // On the exit edge the latched selection is decoded so the new source lands in S1
  // exactly when sel_busy drops.
  always_comb begin
    dec_sel  = (state == ST_MUTE) ? latched_sel : active_sel;
    dec_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (dec_sel == SEL_W'(c)) dec_word = bus.adc_data[c*LW +: LW];
    end
    if (dec_sel == SEL_RAMP) dec_word = ramp_word;
  end

  always_comb begin
    stay_run  = (state == ST_RUN) && (bus.output_select == active_sel);
    exit_mute = (state == ST_MUTE) && (bus.output_select == latched_sel) && (cnt == '0);
    s1_d      = (stay_run || exit_mute) ? dec_word : '0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      cnt         <= '0;
      active_sel  <= SEL_ZERO;
      latched_sel <= SEL_ZERO;
      sel_busy    <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.output_select != active_sel) begin
            state       <= ST_MUTE;
            cnt         <= CNT_W'(MUTE_CYCLES - 1);
            latched_sel <= bus.output_select;
            sel_busy    <= 1'b1;
          end
        end
        ST_MUTE: begin
          if (bus.output_select != latched_sel) begin
            latched_sel <= bus.output_select;
            cnt         <= CNT_W'(MUTE_CYCLES - 1);
          end else if (cnt == '0) begin
            state      <= ST_RUN;
            active_sel <= bus.output_select;
            sel_busy   <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ramp_acc <= '0;
      s1       <= '0;
      dbg_q    <= '0;
    end else begin
      ramp_acc <= ramp_acc + SW'(SPC) * bus.ramp_inc;
      s1       <= s1_d;
      if (!bus.dbg_freeze) dbg_q <= s1_d;
    end
  end

  for (genvar k = 0; k < SPC; k++) begin : g_lane
    tx_lane_gain_sat #(.SW(SW)) u_lane (
      .clock  (clock),
      .reset  (reset),
      .sample (s1[k*SW +: SW]),
      .gain   (bus.gain),
      .result (dac_word[k*SW +: SW])
    );
  end

  assign bus.dac_data        = dac_word;
  assign bus.dbg_output_data = dbg_q;
  assign bus.sel_busy        = sel_busy;

endmodule

// File: tb/tb_tx_core_mux.sv
// Randomised bench for tx_core_mux against a word-level reference model of select,
// mute window, ramp source and gain/round/saturate behaviour.
module tb_tx_core_mux;
  import tx_core_pkg::*;

  localparam int NUM_CH = 4;
  localparam int SPC    = 8;
  localparam int SW     = 16;
  localparam int MUTE   = 16;
  localparam int LW     = SPC * SW;
  localparam int AW     = NUM_CH * LW;
  localparam int SRC_R  = NUM_CH;
  localparam int SRC_Z  = NUM_CH + 1;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tx_core_mux_if #(.NUM_CH(NUM_CH), .SPC(SPC), .SW(SW)) bus ();

  tx_core_mux #(.NUM_CH(NUM_CH), .SPC(SPC), .SW(SW), .MUTE_CYCLES(MUTE)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  int            m_active, m_target, m_zero_left;
  bit            m_busy;
  logic [SW-1:0] m_acc;
  logic [LW-1:0] m_s1, m_s2_word, m_dac, m_dbg;
  logic [15:0]   m_s2_gain;

  function automatic logic [LW-1:0] rep(input logic [SW-1:0] v);
    logic [LW-1:0] w;
    for (int k = 0; k < SPC; k++) w[k*SW +: SW] = v;
    return w;
  endfunction

  function automatic logic [LW-1:0] src_word(input int src, input logic [SW-1:0] acc,
                                             input logic [SW-1:0] inc, input logic [AW-1:0] adc);
    logic [LW-1:0] w;
    w = '0;
    if (src < NUM_CH) w = adc[src*LW +: LW];
    else if (src == SRC_R)
      for (int k = 0; k < SPC; k++) w[k*SW +: SW] = SW'(int'(acc) + k * int'(inc));
    return w;
  endfunction

  function automatic logic [LW-1:0] apply_gain(input logic [LW-1:0] w, input logic [15:0] g);
    logic [LW-1:0] o;
    longint hi, lo;
    hi = (longint'(1) << (SW - 1)) - 1;
    lo = -(longint'(1) << (SW - 1));
    for (int k = 0; k < SPC; k++) begin
      logic signed [SW-1:0] s;
      longint p;
      s = w[k*SW +: SW];
      p = (longint'(s) * longint'(g) + 16384) >>> 15;
      if (p > hi) p = hi;
      else if (p < lo) p = lo;
      o[k*SW +: SW] = SW'(p);
    end
    return o;
  endfunction

  task automatic model_reset();
    m_active = SRC_Z; m_target = SRC_Z; m_zero_left = 0; m_busy = 1'b0;
    m_acc = '0; m_s1 = '0; m_s2_word = '0; m_dac = '0; m_dbg = '0; m_s2_gain = '0;
  endtask

  // One clock: advance the model with the inputs seen at the rising edge, return at the falling edge.
  task automatic step();
    logic [LW-1:0] w;
    int sel;
    bit muted;
    @(posedge clock);
    sel = int'(bus.output_select);
    muted = 1'b0;
    if (m_zero_left == 0) begin
      if (sel != m_active) begin m_target = sel; m_zero_left = MUTE; end
    end else if (sel != m_target) begin
      m_target = sel; m_zero_left = MUTE;
    end
    if (m_zero_left > 0) begin
      muted = 1'b1;
      m_zero_left--;
      if (m_zero_left == 0) m_active = m_target;
    end
    w = muted ? '0 : src_word(m_active, m_acc, bus.ramp_inc, bus.adc_data);
    m_dac = apply_gain(m_s2_word, m_s2_gain);
    m_s2_word = m_s1;
    m_s2_gain = bus.gain;
    m_s1 = w;
    if (!bus.dbg_freeze) m_dbg = w;
    m_busy = muted;
    m_acc = m_acc + SW'(SPC) * bus.ramp_inc;
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.output_select = '0; bus.ramp_inc = 16'd3; bus.gain = GAIN_ONE;
    bus.adc_data = '0; bus.dbg_freeze = 1'b0;
    model_reset();
    repeat (2) @(negedge clock);
    if (bus.dac_data !== '0) begin errors++; $display("FAIL reset_dac: got %h expected 0", bus.dac_data); end
    checks++;
    if (bus.dbg_output_data !== '0) begin errors++; $display("FAIL reset_dbg: got %h expected 0", bus.dbg_output_data); end
    checks++;
    if (bus.sel_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.sel_busy); end
    checks++;
    reset = 1'b0;
  endtask

  task automatic test_select_ch0();
    logic [LW-1:0] exp_w;
    int busy_cnt;
    for (int k = 0; k < SPC; k++) exp_w[k*SW +: SW] = 16'h0100 + SW'(k);
    bus.adc_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom, exp_w};
    busy_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      busy_cnt += int'(bus.sel_busy);
      if (bus.dac_data !== m_dac) begin errors++; $display("FAIL ch0_dac: got %h expected %h", bus.dac_data, m_dac); end
      checks++;
      if (bus.sel_busy !== m_busy) begin errors++; $display("FAIL ch0_busy: got %b expected %b", bus.sel_busy, m_busy); end
      checks++;
      if (bus.dbg_output_data !== m_dbg) begin errors++; $display("FAIL ch0_dbg: got %h expected %h", bus.dbg_output_data, m_dbg); end
      checks++;
    end
    if (busy_cnt != MUTE) begin errors++; $display("FAIL ch0_busy_len: got %0d expected %0d", busy_cnt, MUTE); end
    checks++;
    if (bus.dac_data !== exp_w) begin errors++; $display("FAIL ch0_word: got %h expected %h", bus.dac_data, exp_w); end
    checks++;
  endtask

  task automatic test_ramp();
    logic [SW-1:0] prev, cur;
    int settled, bad;
    bit wrap_seen, have_prev;
    bus.output_select = 5'(SRC_R); bus.ramp_inc = 16'd1; bus.gain = GAIN_ONE;
    settled = 0; bad = 0; wrap_seen = 1'b0; have_prev = 1'b0; prev = '0;
    for (int i = 0; i < 8450; i++) begin
      step();
      if (bus.dac_data !== m_dac) begin errors++; $display("FAIL ramp_dac: got %h expected %h", bus.dac_data, m_dac); end
      checks++;
      if (bus.sel_busy !== m_busy) begin errors++; $display("FAIL ramp_busy: got %b expected %b", bus.sel_busy, m_busy); end
      checks++;
      settled = bus.sel_busy ? 0 : settled + 1;
      if (settled > 3) begin
        for (int k = 0; k < SPC; k++) begin
          cur = bus.dac_data[k*SW +: SW];
          if (have_prev) begin
            if (cur != prev + 16'd1) bad++;
            if (prev == 16'h7FFF && cur == 16'h8000) wrap_seen = 1'b1;
          end
          prev = cur; have_prev = 1'b1;
        end
      end
    end
    if (bad != 0) begin errors++; $display("FAIL ramp_consecutive: got %0d breaks expected 0", bad); end
    checks++;
    if (!wrap_seen) begin errors++; $display("FAIL ramp_wrap: got 0 expected 1"); end
    checks++;
  endtask

  task automatic test_gain_sat();
    logic [LW-1:0] lanes [3];
    logic [15:0]   gains [3];
    logic [LW-1:0] exps  [3];
    lanes[0] = rep(16'h7000); gains[0] = 16'hFFFF; exps[0] = rep(16'h7FFF);
    lanes[1] = rep(16'h9000); gains[1] = 16'hFFFF; exps[1] = rep(16'h8000);
    lanes[2] = rep(16'h0003); gains[2] = 16'h4000; exps[2] = rep(16'h0002);
    bus.output_select = '0;
    bus.adc_data[0 +: LW] = lanes[0]; bus.gain = gains[0];
    repeat (22) step();
    for (int t = 0; t < 3; t++) begin
      bus.adc_data[0 +: LW] = lanes[t]; bus.gain = gains[t];
      repeat (3) step();
      if (bus.dac_data !== exps[t]) begin errors++; $display("FAIL gain_sat_%0d: got %h expected %h", t, bus.dac_data, exps[t]); end
      checks++;
    end
    for (int i = 0; i < 200; i++) begin
      for (int c = 0; c < AW / 32; c++) bus.adc_data[c*32 +: 32] = $urandom;
      if ($urandom_range(0, 3) == 0) bus.gain = 16'($urandom);
      step();
      if (bus.dac_data !== m_dac) begin errors++; $display("FAIL gain_rand_dac: got %h expected %h", bus.dac_data, m_dac); end
      checks++;
    end
  endtask

  task automatic test_mute_restart();
    int busy_cnt;
    bit ch1_seen;
    bus.gain = GAIN_ONE;
    bus.adc_data = {rep(16'h3333), rep(16'h2222), rep(16'h1111), rep(16'h0AAA)};
    repeat (4) step();
    bus.output_select = 5'd1;
    ch1_seen = 1'b0;
    repeat (4) begin
      step();
      for (int k = 0; k < SPC; k++) if (bus.dac_data[k*SW +: SW] == 16'h1111) ch1_seen = 1'b1;
    end
    bus.output_select = 5'd2;
    busy_cnt = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      busy_cnt += int'(bus.sel_busy);
      for (int k = 0; k < SPC; k++) if (bus.dac_data[k*SW +: SW] == 16'h1111) ch1_seen = 1'b1;
      if (bus.dac_data !== m_dac) begin errors++; $display("FAIL restart_dac: got %h expected %h", bus.dac_data, m_dac); end
      checks++;
    end
    if (busy_cnt != MUTE) begin errors++; $display("FAIL restart_busy_len: got %0d expected %0d", busy_cnt, MUTE); end
    checks++;
    if (ch1_seen) begin errors++; $display("FAIL restart_ch1_leak: got 1 expected 0"); end
    checks++;
    if (bus.dac_data !== rep(16'h2222)) begin errors++; $display("FAIL restart_word: got %h expected %h", bus.dac_data, rep(16'h2222)); end
    checks++;
  endtask

  task automatic test_reset_mid_mute();
    bus.output_select = 5'd0;
    step();
    if (bus.dac_data !== rep(16'h2222)) begin errors++; $display("FAIL rst_pre_dac: got %h expected %h", bus.dac_data, rep(16'h2222)); end
    checks++;
    #2 reset = 1'b1;
    #1;
    if (bus.dac_data !== '0) begin errors++; $display("FAIL rst_mid_dac: got %h expected 0", bus.dac_data); end
    checks++;
    if (bus.dbg_output_data !== '0) begin errors++; $display("FAIL rst_mid_dbg: got %h expected 0", bus.dbg_output_data); end
    checks++;
    if (bus.sel_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.sel_busy); end
    checks++;
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    bus.output_select = 5'(SRC_Z);
    repeat (5) begin
      step();
      if (bus.sel_busy !== 1'b0) begin errors++; $display("FAIL rst_zero_busy: got %b expected 0", bus.sel_busy); end
      checks++;
      if (bus.dac_data !== '0) begin errors++; $display("FAIL rst_zero_dac: got %h expected 0", bus.dac_data); end
      checks++;
    end
    bus.output_select = 5'd3;
    step();
    if (bus.sel_busy !== 1'b1) begin errors++; $display("FAIL rst_then_sel_busy: got %b expected 1", bus.sel_busy); end
    checks++;
  endtask

  task automatic test_dbg_freeze();
    logic [LW-1:0] frozen;
    repeat (20) step();
    bus.dbg_freeze = 1'b1;
    frozen = m_dbg;
    for (int i = 0; i < 20; i++) begin
      for (int c = 0; c < LW / 32; c++) bus.adc_data[3*LW + c*32 +: 32] = $urandom;
      step();
      if (bus.dbg_output_data !== frozen) begin errors++; $display("FAIL freeze_dbg: got %h expected %h", bus.dbg_output_data, frozen); end
      checks++;
      if (bus.dac_data !== m_dac) begin errors++; $display("FAIL freeze_dac: got %h expected %h", bus.dac_data, m_dac); end
      checks++;
    end
    bus.dbg_freeze = 1'b0;
    step();
    if (bus.dbg_output_data !== m_dbg) begin errors++; $display("FAIL unfreeze_dbg: got %h expected %h", bus.dbg_output_data, m_dbg); end
    checks++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) bus.output_select = 5'($urandom_range(0, 7));
      for (int c = 0; c < AW / 32; c++) bus.adc_data[c*32 +: 32] = $urandom;
      if ($urandom_range(0, 7) == 0) bus.gain = 16'($urandom);
      if ($urandom_range(0, 15) == 0) bus.ramp_inc = 16'($urandom);
      bus.dbg_freeze = ($urandom_range(0, 3) == 0);
      step();
      if (bus.dac_data !== m_dac) begin errors++; $display("FAIL rand_dac: got %h expected %h", bus.dac_data, m_dac); end
      checks++;
      if (bus.sel_busy !== m_busy) begin errors++; $display("FAIL rand_busy: got %b expected %b", bus.sel_busy, m_busy); end
      checks++;
      if (bus.dbg_output_data !== m_dbg) begin errors++; $display("FAIL rand_dbg: got %h expected %h", bus.dbg_output_data, m_dbg); end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_select_ch0();
    test_ramp();
    test_gain_sat();
    test_mute_restart();
    test_reset_mid_mute();
    test_dbg_freeze();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
